// File: rtl/data_sram_slave.sv
// Word-addressed 32-bit data SRAM slave with byte-lane writes and registered read data.
// Optional wait-state FSM compiled in when DSRAM_WAIT_EN is defined.
module data_sram_slave #(
  parameter int ADDR_W   = 12,
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       rdata_q;
  logic              go;
  logic [3:0]        acc_wen;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic [ADDR_W-1:0] idx;

`ifdef DSRAM_WAIT_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  wen_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  // Request is captured on acceptance so later input changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (data_sram_en) begin
            addr_q  <= data_sram_addr;
            wen_q   <= data_sram_wen;
            wdata_q <= data_sram_wdata;
            cnt_q   <= 4'(WAIT_CYC - 1);
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) state_q <= S_DONE;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign go        = (state_q == S_DONE);
  assign acc_wen   = wen_q;
  assign acc_addr  = addr_q;
  assign acc_wdata = wdata_q;
  assign stallreq  = !rst && (((state_q == S_IDLE) && data_sram_en) || (state_q == S_WAIT));
`else
  logic unused_cfg;

  assign go         = data_sram_en;
  assign acc_wen    = data_sram_wen;
  assign acc_addr   = data_sram_addr;
  assign acc_wdata  = data_sram_wdata;
  assign stallreq   = 1'b0;
  assign unused_cfg = (WAIT_CYC != 0);
`endif

  // Byte offset and bits above the array size are dropped, so addresses wrap.
  logic unused_addr;
  assign unused_addr = ^{acc_addr[31:ADDR_W+2], acc_addr[1:0]};
  assign idx         = acc_addr[ADDR_W+1:2];

  always_ff @(posedge clk) begin
    if (go && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wen[i]) mem_q[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                            rdata_q <= 32'h0;
    else if (go && (acc_wen == 4'b0000)) rdata_q <= mem_q[idx];
  end

  assign data_sram_rdata = rdata_q;

endmodule

// File: tb/tb_data_sram_slave.sv
// Directed self-checking bench for data_sram_slave; exercises the wait-state
// path instead of the single-cycle path when DSRAM_WAIT_EN is defined.
module tb_data_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_sram_slave #(.ADDR_W(12), .WAIT_CYC(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .stallreq        (stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef DSRAM_WAIT_EN
  // Hold the request through IDLE/WAIT/WAIT/DONE, then drop it; stall must go 1,1,1,0,0.
  task automatic acc(input string tag, input logic [3:0] w, input logic [31:0] a,
                     input logic [31:0] d);
    en = 1'b1; wen = w; addr = a; wdata = d;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk({tag, "_stall"}, {31'h0, stall}, {31'h0, (c < 3)});
      tick();
    end
    en = 1'b0;
    #1;
    chk({tag, "_noreaccept"}, {31'h0, stall}, 32'h0);
  endtask
`else
  task automatic acc(input string tag, input logic [3:0] w, input logic [31:0] a,
                     input logic [31:0] d);
    en = 1'b1; wen = w; addr = a; wdata = d;
    #1;
    chk({tag, "_stall"}, {31'h0, stall}, 32'h0);
    tick();
    en = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
    #1;
    chk("stall_in_rst", {31'h0, stall}, 32'h0);
    tick();
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    rst = 1'b0;

    // Full-word write then read-back of the same word on the next access
    acc("wr10", 4'hF, 32'h10, 32'hDEADBEEF);
    chk("wr_keeps_rdata", rdata, 32'h0);
    acc("rd10", 4'h0, 32'h10, 32'h0);
    chk("rd10", rdata, 32'hDEADBEEF);

    // Idle cycle with changed inputs leaves rdata alone
    en = 1'b0; addr = 32'h20; wen = 4'hF; wdata = 32'hFFFFFFFF;
    tick();
    chk("idle_hold", rdata, 32'hDEADBEEF);

    // Byte lanes
    acc("wr20", 4'hF, 32'h20, 32'h11223344);
    acc("wr20_b2", 4'b0100, 32'h20, 32'h00AA0000);
    chk("wr_lane_keeps_rdata", rdata, 32'hDEADBEEF);
    acc("rd20", 4'h0, 32'h20, 32'h0);
    chk("rd20_lane2", rdata, 32'h11AA3344);
    acc("wr20_b30", 4'b1001, 32'h20, 32'hFF0000EE);
    acc("rd20b", 4'h0, 32'h22, 32'h0);
    chk("rd20_lane30", rdata, 32'hFFAA33EE);

    // Address wrap and ignored byte offset
    acc("wr4004", 4'hF, 32'h4004, 32'h00000055);
    acc("rd0004", 4'h0, 32'h0004, 32'h0);
    chk("wrap_rd4", rdata, 32'h00000055);
    acc("rd10b", 4'h0, 32'h10, 32'h0);
    chk("no_alias", rdata, 32'hDEADBEEF);
    acc("rd0007", 4'h0, 32'h0007, 32'h0);
    chk("wrap_rd7", rdata, 32'h00000055);

    // Reset clears rdata but not the array
    rst = 1'b1;
    tick();
    chk("rst2_rdata", rdata, 32'h0);
    rst = 1'b0;
    acc("rd10c", 4'h0, 32'h10, 32'h0);
    chk("mem_kept", rdata, 32'hDEADBEEF);

`ifdef DSRAM_WAIT_EN
    // Reset in WAIT aborts a pending write
    acc("wr30", 4'hF, 32'h30, 32'h12345678);
    en = 1'b1; wen = 4'hF; addr = 32'h30; wdata = 32'h0;
    tick();
    rst = 1'b1;
    #1;
    chk("abort_stall_rst", {31'h0, stall}, 32'h0);
    tick();
    rst = 1'b0; en = 1'b0;
    #1;
    chk("abort_stall", {31'h0, stall}, 32'h0);
    chk("abort_rdata", rdata, 32'h0);
    acc("rd30", 4'h0, 32'h30, 32'h0);
    chk("abort_no_write", rdata, 32'h12345678);

    // Input change after acceptance does not affect the latched read
    acc("wr40", 4'hF, 32'h40, 32'hA0A0A0A0);
    acc("wr44", 4'hF, 32'h44, 32'hB4B4B4B4);
    en = 1'b1; wen = 4'h0; addr = 32'h40;
    tick();
    addr = 32'h44; wen = 4'hF; wdata = 32'hBAD0BAD0;
    tick();
    tick();
    en = 1'b0;
    tick();
    chk("latched_addr", rdata, 32'hA0A0A0A0);
    acc("rd44", 4'h0, 32'h44, 32'h0);
    chk("latched_wen", rdata, 32'hB4B4B4B4);
`else
    // Write immediately followed by read of the same word
    en = 1'b1; wen = 4'hF; addr = 32'h30; wdata = 32'h12345678;
    tick();
    wen = 4'h0;
    tick();
    en = 1'b0;
    chk("b2b", rdata, 32'h12345678);
    chk("b2b_stall", {31'h0, stall}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
